sisc_mem_arbiter: RTL and testbench
===================================

# sisc_mem_arbiter

Arbiter and sequencer for the single-ported unified SISC memory. It shares the memory between two requesters: the instruction-fetch path (IR load in the fetch state) and the data path (LOD/STR in the mem state). It accepts one access at a time, drives the memory for a programmable number of wait cycles, and returns read data with a one-cycle done pulse to the requester that was granted.

## Interface
- AW, 16, address width
- DW, 32, data width
- MEM_LAT, 2, memory access cycles; legal range 1..7
- clk  input  1  clock, rising edge
- rst_f  input  1  reset, asynchronous, active-low
- if_req  input  1  fetch request, level
- if_addr  input  AW  fetch address
- if_gnt  output  1  fetch accepted, one-cycle pulse
- if_done  output  1  fetch complete, one-cycle pulse
- if_rdata  output  DW  fetch read data
- dm_req  input  1  data request, level
- dm_we  input  1  data write when 1
- dm_addr  input  AW  data address
- dm_wdata  input  DW  data write value
- dm_gnt  output  1  data accepted, one-cycle pulse
- dm_done  output  1  data complete, one-cycle pulse
- dm_rdata  output  DW  data read value
- mem_en  output  1  memory enable
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data
- busy  output  1  high in every state except IDLE

## Operation
- All outputs are registered. On reset (rst_f low): state is IDLE, every output is 0, rdata registers are 0, and last_grant is set to FETCH.
- States: IDLE, ACCESS, DONE.
- IDLE: the arbiter samples if_req and dm_req.
  - Neither request high: stay in IDLE.
  - One or both high: pick a winner, latch its address, we and wdata into the mem_* registers, pulse the winner's gnt, load the wait counter with MEM_LAT-1, and go to ACCESS.
- ACCESS: mem_en is 1, and mem_we is 1 only for a data write. mem_addr and mem_wdata stay stable throughout.
  - While the counter is nonzero, decrement it.
  - When the counter is 0:
    - For a read, capture mem_rdata into the winner's rdata register.
    - Pulse the winner's done.
    - Clear mem_en and mem_we.
    - Go to DONE.
- DONE: done is high for this single cycle, and rdata is valid from here until the next read by the same requester. No arbitration happens in DONE. The next state is IDLE.
- Requester rule: hold req, addr, we and wdata from req high until the done cycle, and deassert req on the edge that ends the done cycle. A req still high in IDLE is treated as a new access.
- Writes leave the dm_rdata register unchanged.
- Priority (default): dm wins when both requests are high. The data access in the mem state must not stall behind a fetch.
- Reset mid-access: the access is abandoned, no done is issued, and memory contents are undefined for an interrupted write.

## Timing
- req is sampled high in IDLE at edge k. Then:
  - gnt is high in cycle k+1.
  - mem_en is high in cycles k+1 .. k+MEM_LAT.
  - done is high in cycle k+MEM_LAT+1.
  - IDLE is re-entered at cycle k+MEM_LAT+2.
- Minimum spacing between the start of two accesses is MEM_LAT+2 cycles.
- mem_rdata must be valid in the last cycle in which mem_en is high. It is sampled on the edge that ends ACCESS.

## Configuration
- SISC_ARB_RR_EN defined:
  - Round-robin between the two requesters. When both requests are high in IDLE, the requester that is not last_grant wins.
  - last_grant updates on every grant.
- SISC_ARB_RR_EN undefined:
  - Fixed priority, with dm always winning.
  - The last_grant register is not built.

## Structure
- Shared package sisc_mem_pkg holds:
  - The state enum (IDLE, ACCESS, DONE).
  - Requester IDs FETCH=0 and DATA=1.
  - Default AW and DW values.
- Sub-module sisc_wait_cnt: a 3-bit loadable down-counter with a zero flag. The ACCESS state instantiates it.

## Test plan
- Reset: assert rst_f low in the second ACCESS cycle of a fetch -> the next cycle has busy=0, mem_en=0, and no if_done ever appears. After release, an idle bench stays in IDLE.
- Single fetch: MEM_LAT=2, if_req at edge 0, if_addr=0x0010, mem_rdata=0x8A000005 -> if_gnt in cycle 1, mem_en in cycles 1–2 with mem_addr=0x0010, and if_done in cycle 3 with if_rdata=0x8A000005.
- Data write: dm_we=1, dm_addr=0x0020, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_en=1 for 2 cycles with those values, dm_done in cycle 3, and dm_rdata unchanged.
- Contention, fixed priority: if_req and dm_req both held high, each dropping after its own done -> dm is served first (dm_done in cycle 3), then fetch (if_gnt in cycle 5, if_done in cycle 7).
- Contention with SISC_ARB_RR_EN: both requesters re-request continuously for 4 accesses -> the grant order is dm, if, dm, if. Without the macro, the order is dm, dm, dm, dm.
- Boundary MEM_LAT=1: a single read at 0x0003 -> mem_en is high for exactly 1 cycle and done comes in cycle 2. With MEM_LAT=7, mem_en is high for 7 cycles and done comes in cycle 8.

Source files
------------

// File: rtl/sisc_mem_arbiter_pkg.sv
// Purpose: shared types for the SISC memory arbiter (states, requester IDs, default widths).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_t;

  localparam int SISC_AW = 16;
  localparam int SISC_DW = 32;

  // Fixed priority: the data path always wins so LOD/STR never wait on a fetch.
  function automatic req_id_t pick_fixed(input logic dm_req);
    return dm_req ? DATA : FETCH;
  endfunction

  // Round-robin: on contention the requester that did not win last time goes.
  function automatic req_id_t pick_rr(input logic if_req, input logic dm_req,
                                      input req_id_t last);
    if (if_req && dm_req) return (last == FETCH) ? DATA : FETCH;
    else if (dm_req)      return DATA;
    else                  return FETCH;
  endfunction

endpackage

// File: rtl/sisc_mem_arbiter_if.sv
// Purpose: bundle of requester, memory and status signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their done pulse; no other throttling.
interface sisc_mem_arbiter_if
  import sisc_mem_pkg::*;
#(
  parameter int AW = SISC_AW,
  parameter int DW = SISC_DW
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  // Environment side: the two requesters plus the memory read port.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/sisc_mem_arbiter_wait_cnt.sv
// Purpose: 3-bit loadable down-counter with zero flag, paces the memory access.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; saturates at zero.
module sisc_wait_cnt (
  input  logic       clk,
  input  logic       rst_f,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] cnt;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)                   cnt <= 3'd0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != 3'd0)  cnt <= cnt - 3'd1;
  end

  assign zero = (cnt == 3'd0);

endmodule

// File: rtl/sisc_mem_arbiter.sv
// Purpose: shares the unified SISC memory between fetch and data paths (define SISC_ARB_RR_EN for round-robin).
// Latency: gnt 1 cycle after req sampled, mem_en MEM_LAT cycles, done at MEM_LAT+1; next access MEM_LAT+2 after start.
// Backpressure: one access in flight; a losing requester simply keeps req high until it is granted.
module sisc_mem_arbiter
  import sisc_mem_pkg::*;
#(
  parameter int AW      = SISC_AW,
  parameter int DW      = SISC_DW,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  sisc_mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  arb_state_t    state;
  req_id_t       owner;
  req_id_t       winner;
  logic          start;
  logic          cnt_zero;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef SISC_ARB_RR_EN
  req_id_t last_grant;

  assign winner = pick_rr(bus.if_req, bus.dm_req, last_grant);

  // Remember who won so the other side gets the next contended slot.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)     last_grant <= FETCH;
    else if (start) last_grant <= winner;
  end
`else
  assign winner = pick_fixed(bus.dm_req);
`endif

  assign start     = (state == IDLE) && (bus.if_req || bus.dm_req);
  assign sel_addr  = (winner == DATA) ? bus.dm_addr : bus.if_addr;
  assign sel_wdata = (winner == DATA) ? bus.dm_wdata : '0;

  sisc_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_f    (rst_f),
    .load     (start),
    .load_val (LAT_LOAD),
    .dec      (state == ACCESS),
    .zero     (cnt_zero)
  );

  // Access sequencer: arbitrate in IDLE, hold the memory bus in ACCESS, pulse done in DONE.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state         <= IDLE;
      owner         <= FETCH;
      bus.if_gnt    <= 1'b0;
      bus.if_done   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_gnt    <= 1'b0;
      bus.dm_done   <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_gnt  <= 1'b0;
      bus.dm_gnt  <= 1'b0;
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= ACCESS;
            owner         <= winner;
            bus.busy      <= 1'b1;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= (winner == DATA) && bus.dm_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            if (winner == DATA) bus.dm_gnt <= 1'b1;
            else                bus.if_gnt <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            state      <= DONE;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            if (owner == DATA) begin
              bus.dm_done <= 1'b1;
              if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
            end else begin
              bus.if_done  <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_mem_arbiter.sv
// Purpose: self-checking bench for sisc_mem_arbiter at MEM_LAT 1, 2 and 7.
// Latency: n/a.
// Backpressure: n/a.
module tb_sisc_mem_arbiter;
  import sisc_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  always #5 clk = ~clk;

  int            sel = 2;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] mem_img [256];

  sisc_mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  sisc_mem_arbiter_if #(.AW(AW), .DW(DW)) b2 ();
  sisc_mem_arbiter_if #(.AW(AW), .DW(DW)) b7 ();

  sisc_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (.clk(clk), .rst_f(rst_f), .bus(b1.slave));
  sisc_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) dut2 (.clk(clk), .rst_f(rst_f), .bus(b2.slave));
  sisc_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(7)) dut7 (.clk(clk), .rst_f(rst_f), .bus(b7.slave));

  assign b1.if_req = if_req && (sel == 1);  assign b1.dm_req = dm_req && (sel == 1);
  assign b2.if_req = if_req && (sel == 2);  assign b2.dm_req = dm_req && (sel == 2);
  assign b7.if_req = if_req && (sel == 7);  assign b7.dm_req = dm_req && (sel == 7);
  assign b1.if_addr = if_addr;  assign b1.dm_addr = dm_addr;  assign b1.dm_we = dm_we;  assign b1.dm_wdata = dm_wdata;
  assign b2.if_addr = if_addr;  assign b2.dm_addr = dm_addr;  assign b2.dm_we = dm_we;  assign b2.dm_wdata = dm_wdata;
  assign b7.if_addr = if_addr;  assign b7.dm_addr = dm_addr;  assign b7.dm_we = dm_we;  assign b7.dm_wdata = dm_wdata;
  assign b1.mem_rdata = mem_img[b1.mem_addr[7:0]];
  assign b2.mem_rdata = mem_img[b2.mem_addr[7:0]];
  assign b7.mem_rdata = mem_img[b7.mem_addr[7:0]];

  logic          o_if_gnt, o_if_done, o_dm_gnt, o_dm_done, o_mem_en, o_mem_we, o_busy;
  logic [DW-1:0] o_if_rdata, o_dm_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;

  always_comb begin
    o_if_gnt = b2.if_gnt; o_if_done = b2.if_done; o_if_rdata = b2.if_rdata;
    o_dm_gnt = b2.dm_gnt; o_dm_done = b2.dm_done; o_dm_rdata = b2.dm_rdata;
    o_mem_en = b2.mem_en; o_mem_we = b2.mem_we; o_mem_addr = b2.mem_addr;
    o_mem_wdata = b2.mem_wdata; o_busy = b2.busy;
    if (sel == 1) begin
      o_if_gnt = b1.if_gnt; o_if_done = b1.if_done; o_if_rdata = b1.if_rdata;
      o_dm_gnt = b1.dm_gnt; o_dm_done = b1.dm_done; o_dm_rdata = b1.dm_rdata;
      o_mem_en = b1.mem_en; o_mem_we = b1.mem_we; o_mem_addr = b1.mem_addr;
      o_mem_wdata = b1.mem_wdata; o_busy = b1.busy;
    end else if (sel == 7) begin
      o_if_gnt = b7.if_gnt; o_if_done = b7.if_done; o_if_rdata = b7.if_rdata;
      o_dm_gnt = b7.dm_gnt; o_dm_done = b7.dm_done; o_dm_rdata = b7.dm_rdata;
      o_mem_en = b7.mem_en; o_mem_we = b7.mem_we; o_mem_addr = b7.mem_addr;
      o_mem_wdata = b7.mem_wdata; o_busy = b7.busy;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          is_dm;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t sb[$];

  task automatic sb_push(input logic is_dm, input logic [DW-1:0] rdata);
    sb_t e;
    e.is_dm = is_dm;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Every done pulse must match the next expected completion.
  always @(negedge clk) begin
    if (o_if_done || o_dm_done) begin
      if (sb.size() == 0) begin
        chkb("unexpected_done", 1'b1, 1'b0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chkb("done_src", o_dm_done, e.is_dm);
        chkw("done_rdata", 64'(e.is_dm ? o_dm_rdata : o_if_rdata), 64'(e.rdata));
      end
    end
  end

  // Grant order log for the contention sequences.
  logic [7:0] gq[$];
  always @(negedge clk) begin
    if (o_dm_gnt) gq.push_back(8'h44);
    if (o_if_gnt) gq.push_back(8'h49);
  end

  // One isolated access: cycle c counts from the edge that samples req.
  task automatic run_access(input int s, input int lat, input logic isdm, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [DW-1:0] exp_rd, input string nm);
    int en_cnt;
    en_cnt = 0;
    @(negedge clk);
    sel = s;
    sb_push(isdm, exp_rd);
    if (isdm) begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; end
    else      begin if_req = 1'b1; if_addr = a; end
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      chkb({nm, "_gnt"}, isdm ? o_dm_gnt : o_if_gnt, c == 1);
      chkb({nm, "_done"}, isdm ? o_dm_done : o_if_done, c == lat + 1);
      chkb({nm, "_mem_en"}, o_mem_en, c <= lat);
      if (o_mem_en) begin
        en_cnt++;
        chkw({nm, "_mem_addr"}, 64'(o_mem_addr), 64'(a));
        chkb({nm, "_mem_we"}, o_mem_we, isdm && we);
        if (isdm && we) chkw({nm, "_mem_wdata"}, 64'(o_mem_wdata), 64'(wd));
      end
      if (c == lat + 1) begin if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; end
      if (c == lat + 2) chkb({nm, "_idle"}, o_busy, 1'b0);
    end
    chkw({nm, "_en_cycles"}, 64'(en_cnt), 64'(lat));
  endtask

  typedef struct {
    logic          is_dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_dg, t_dd, t_ig, t_id;
    string exp_ord;

    for (int i = 0; i < 256; i++) mem_img[i] = {8'(i), 8'hEE, 8'(i), 8'h11};

    vt[0] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'h8A000005, 32'h8A000005};
    vt[1] = '{1'b1, 1'b1, 16'h0020, 32'hDEADBEEF, 32'hBADBAD00, 32'h00000000};
    vt[2] = '{1'b1, 1'b0, 16'h0030, 32'h0,        32'h12345678, 32'h12345678};
    vt[3] = '{1'b1, 1'b1, 16'h0040, 32'hCAFEF00D, 32'hBADBAD01, 32'h12345678};
    vt[4] = '{1'b0, 1'b0, 16'hFFFF, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[5] = '{1'b1, 1'b0, 16'h0001, 32'h0,        32'h0000A5A5, 32'h0000A5A5};

    // Reset state.
    repeat (2) @(negedge clk);
    chkb("rst_busy", o_busy, 1'b0);
    chkb("rst_mem_en", o_mem_en, 1'b0);
    chkb("rst_mem_we", o_mem_we, 1'b0);
    chkw("rst_mem_addr", 64'(o_mem_addr), 64'h0);
    chkb("rst_if_gnt", o_if_gnt, 1'b0);
    chkb("rst_dm_gnt", o_dm_gnt, 1'b0);
    chkb("rst_if_done", o_if_done, 1'b0);
    chkb("rst_dm_done", o_dm_done, 1'b0);
    chkw("rst_if_rdata", 64'(o_if_rdata), 64'h0);
    chkw("rst_dm_rdata", 64'(o_dm_rdata), 64'h0);
    rst_f = 1'b1;

    // Table of isolated accesses at MEM_LAT=2.
    for (int i = 0; i < 6; i++) begin
      mem_img[vt[i].addr[7:0]] = vt[i].mem;
      run_access(2, 2, vt[i].is_dm, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd,
                 $sformatf("vec%0d", i));
    end
    chkw("if_rdata_hold", 64'(o_if_rdata), 64'hFFFFFFFF);

    // Reset in the second ACCESS cycle of a fetch.
    @(negedge clk);
    sel = 2; if_req = 1'b1; if_addr = 16'h0050;
    @(negedge clk);
    chkb("rstmid_busy_before", o_busy, 1'b1);
    @(negedge clk);
    rst_f = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chkb("rstmid_busy", o_busy, 1'b0);
    chkb("rstmid_mem_en", o_mem_en, 1'b0);
    chkw("rstmid_if_rdata", 64'(o_if_rdata), 64'h0);
    rst_f = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chkb("rstmid_no_done", o_if_done, 1'b0);
      chkb("rstmid_idle", o_busy, 1'b0);
    end

    // Contention: both held, each drops after its own done.
    mem_img[8'h60] = 32'h600D0060;
    mem_img[8'h70] = 32'h70707070;
    sb_push(1'b1, 32'h600D0060);
    sb_push(1'b0, 32'h70707070);
    t_dg = -1; t_dd = -1; t_ig = -1; t_id = -1;
    @(negedge clk);
    sel = 2; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0060; if_req = 1'b1; if_addr = 16'h0070;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (o_dm_gnt && t_dg < 0)  t_dg = c;
      if (o_dm_done && t_dd < 0) t_dd = c;
      if (o_if_gnt && t_ig < 0)  t_ig = c;
      if (o_if_done && t_id < 0) t_id = c;
      if (o_dm_done) dm_req = 1'b0;
      if (o_if_done) if_req = 1'b0;
    end
    chkw("cont_dm_gnt_cyc", 64'(t_dg), 64'(1));
    chkw("cont_dm_done_cyc", 64'(t_dd), 64'(3));
    chkw("cont_if_gnt_cyc", 64'(t_ig), 64'(5));
    chkw("cont_if_done_cyc", 64'(t_id), 64'(7));

    // Continuous contention for four accesses.
`ifdef SISC_ARB_RR_EN
    exp_ord = "DIDI";
`else
    exp_ord = "DDDD";
`endif
    for (int i = 0; i < 4; i++)
      if (exp_ord[i] == "D") sb_push(1'b1, 32'h600D0060);
      else                   sb_push(1'b0, 32'h70707070);
    @(negedge clk);
    gq.delete();
    dm_req = 1'b1; if_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 15) begin dm_req = 1'b0; if_req = 1'b0; end
    end
    @(negedge clk);
    chkw("order_len", 64'(gq.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      chkw($sformatf("order%0d", i), 64'((i < gq.size()) ? gq[i] : 8'h00), 64'(exp_ord[i]));

    // MEM_LAT boundaries.
    mem_img[8'h03] = 32'h00030003;
    run_access(1, 1, 1'b0, 1'b0, 16'h0003, 32'h0, 32'h00030003, "lat1");
    mem_img[8'h77] = 32'h77770077;
    run_access(7, 7, 1'b1, 1'b0, 16'h0077, 32'h0, 32'h77770077, "lat7");

    @(negedge clk);
    chkw("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
